block_packer: RTL and testbench
===============================

BLOCK_PACKER -- requirements
Module: block_packer

Interface
REQ-001 Parameter BUF_W, default 40, SHALL set the bit-buffer width (8 + 31 + 1).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 start  in  1  SHALL be a one-cycle tick that latches n_key, clears the buffer and begins length measurement.
REQ-005 n_key  in  32  SHALL be the RSA modulus, sampled only on start.
REQ-006 byte_in  in  8  SHALL be the received data byte.
REQ-007 byte_valid  in  1  SHALL be a one-cycle tick qualifying byte_in.
REQ-008 flush  in  1  SHALL be a one-cycle tick requesting emission of a zero-padded final partial block.
REQ-009 block_ready  in  1  SHALL indicate that the downstream crypter accepts block_out this cycle.
REQ-010 block_valid  out  1  SHALL flag that block_out holds a valid message block.
REQ-011 block_out  out  32  SHALL carry a right-aligned W-bit message block; upper bits are zero.
REQ-012 busy  out  1  SHALL be high during length measurement.
REQ-013 key_err  out  1  SHALL be a sticky flag for an unusable modulus.
REQ-014 ovf  out  1  SHALL be a sticky flag set when a byte is dropped.

Function
REQ-015 States SHALL be IDLE, MEASURE, RUN, OUT and ERR; the block SHALL leave reset in IDLE.
REQ-016 IDLE->MEASURE on start: copy n_key to a shift register and clear L, cnt and pending flush.
REQ-017 MEASURE, each cycle: if the shift register is non-zero, shift right by 1 and L++; otherwise go to RUN if L>=2, else to ERR.
REQ-018 Block width SHALL be W = L-1 (1..31), which guarantees every block is < n_key.
REQ-019 In RUN or OUT, a byte_valid with cnt+8 <= BUF_W SHALL append byte_in MSB-first, after previously buffered bits, and set cnt += 8.
REQ-020 Otherwise a byte_valid in RUN or OUT SHALL drop the byte and set ovf.
REQ-021 byte_valid in IDLE, MEASURE or ERR SHALL drop the byte and set ovf.
REQ-022 In RUN with cnt >= W, the block SHALL register the oldest W bits into block_out, set cnt -= W and go to OUT.
REQ-023 A byte completing a block in cycle t SHALL produce block_valid high in cycle t+2.
REQ-024 OUT SHALL hold block_valid=1 with block_out stable until block_valid & block_ready, then return to RUN with block_valid=0 on the next cycle.
REQ-025 A flush tick SHALL set a pending flag, including when it arrives in OUT.
REQ-026 In RUN with the pending flag set and 0 < cnt < W, the block SHALL pad zeros to W bits, emit per REQ-022, and clear the pending flag.
REQ-027 In RUN with the pending flag set and cnt == 0, the pending flag SHALL clear with no emission.
REQ-028 byte_valid and flush in the same cycle SHALL append the byte first, then apply the flush to the resulting buffer.
REQ-029 start in any state SHALL abort any held block (block_valid=0), drop a coincident byte, and restart at MEASURE; key_err and ovf SHALL clear.
REQ-030 ERR SHALL hold key_err=1 and accept nothing until start or rst.

Reset
REQ-031 On rst, state SHALL be IDLE and block_valid, block_out, busy, key_err, ovf, cnt, L and the pending flag SHALL all be 0.
REQ-032 rst SHALL take priority over start and every other input in the same cycle.

Structure
REQ-033 State encodings and BUF_W SHALL reside in the shared package rsa_pkg.
REQ-034 Length measurement SHALL be a sub-module bit_len_meter (inputs: load, value; outputs: len, done).
REQ-035 The block SHALL use no division and no multipliers; the buffer SHALL be shift-and-count only.

Verification
REQ-036 n_key=3233 (0xCA1) -> busy falls within 15 cycles of start and W=11.
REQ-037 With W=11, bytes 0xAB then 0xCD, block_ready=1 -> block_out=0x55E, then on flush block_out=0x340.
REQ-038 n_key=1 -> key_err=1, no block_valid; a subsequent start with n_key=3233 clears key_err.
REQ-039 block_ready=0 for 10 cycles during OUT -> block_out stable and bytes accepted up to BUF_W; the 5th extra byte sets ovf.
REQ-040 rst asserted while in OUT -> block_valid=0 the next cycle and all outputs at reset values.
REQ-041 byte_valid and flush coincident with cnt=0, W=11 -> blocks emitted are the byte's top 8 bits padded with 3 zeros.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA message block packer: buffer sizing,
// key/length widths and the packer state encoding.
package rsa_pkg;

  // Bit buffer holds one partial block (up to 30 bits) plus one more byte,
  // rounded up: 8 + 31 + 1.
  localparam int BUF_W = 40;

  // Modulus width and the width needed to hold its bit length (0..32).
  localparam int KEY_W = 32;
  localparam int LEN_W = 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEASURE = 3'd1,
    S_RUN     = 3'd2,
    S_OUT     = 3'd3,
    S_ERR     = 3'd4
  } state_e;

endpackage

// File: rtl/bit_len_meter.sv
// Measures the bit length of a value by shifting it right one bit per
// cycle until it reaches zero. done is high for the single cycle in which
// the shift register is empty; len then holds the bit length and keeps it
// until the next load.
module bit_len_meter
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [KEY_W-1:0] value,
  output logic [LEN_W-1:0] len,
  output logic             done
);

  logic [KEY_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             act_q, act_d;

  // Next-state: load restarts the measurement, otherwise shift and count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    sh_d  = sh_q;
    len_d = len_q;
    act_d = act_q;
    if (load) begin
      sh_d  = value;
      len_d = '0;
      act_d = 1'b1;
    end else if (act_q) begin
      if (sh_q != '0) begin
        sh_d  = sh_q >> 1;
        len_d = len_q + LEN_W'(1);
      end else begin
        act_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here, so every register samples the
    // values from before the edge regardless of statement order.
    if (rst) begin
      sh_q  <= '0;
      len_q <= '0;
      act_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      len_q <= len_d;
      act_q <= act_d;
    end
  end

  assign len  = len_q;
  assign done = act_q && (sh_q == '0);

endmodule

// File: rtl/block_packer.sv
// Packs a byte stream into right-aligned W-bit message blocks for an RSA
// crypter, where W is one less than the bit length of the modulus so every
// block is numerically below it. Bits are buffered MSB-first, left-aligned
// in a shift register, so the oldest W bits are always the top W bits and
// zero padding of a final partial block falls out for free.
module block_packer #(
  parameter int BUF_W = rsa_pkg::BUF_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] n_key,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        flush,
  input  logic        block_ready,
  output logic        block_valid,
  output logic [31:0] block_out,
  output logic        busy,
  output logic        key_err,
  output logic        ovf
);

  import rsa_pkg::state_e;
  import rsa_pkg::S_IDLE;
  import rsa_pkg::S_MEASURE;
  import rsa_pkg::S_RUN;
  import rsa_pkg::S_OUT;
  import rsa_pkg::S_ERR;
  import rsa_pkg::LEN_W;

  localparam int CNT_W = $clog2(BUF_W + 1);

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      blk_q, blk_d;

  logic [LEN_W-1:0] key_len;
  logic             len_done;
  logic [CNT_W-1:0] w;
  logic [BUF_W-1:0] byte_ext;
  logic [BUF_W-1:0] buf_w;
  logic [CNT_W-1:0] cnt_w;
  logic             emit;

  bit_len_meter u_meter (
    .clk   (clk),
    .rst   (rst),
    .load  (start),
    .value (n_key),
    .len   (key_len),
    .done  (len_done)
  );

  // Block width; only meaningful once measurement has produced L >= 2.
  assign w        = CNT_W'(key_len) - CNT_W'(1);
  assign byte_ext = {byte_in, {(BUF_W - 8){1'b0}}};

  // Next-state: FSM transitions, block extraction, byte append, flags.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    blk_d   = blk_q;
    buf_w   = buf_q;
    cnt_w   = cnt_q;
    emit    = 1'b0;

    if (start) begin
      // Abort everything, including a held block and a coincident byte.
      state_d = S_MEASURE;
      buf_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
      ovf_d   = 1'b0;
      blk_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (byte_valid) ovf_d = 1'b1;
        end

        S_MEASURE: begin
          if (byte_valid) ovf_d = 1'b1;
          if (len_done) state_d = (key_len >= LEN_W'(2)) ? S_RUN : S_ERR;
        end

        S_RUN, S_OUT: begin
          // A full block wins over a pending flush; the flush then catches
          // whatever partial block remains on a later pass through RUN.
          if (state_q == S_RUN) begin
            if (cnt_q >= w) begin
              emit = 1'b1;
            end else if (pend_q) begin
              pend_d = 1'b0;
              emit   = (cnt_q != '0);
            end
          end

          if (emit) begin
            blk_d   = 32'(buf_q >> (CNT_W'(BUF_W) - w));
            buf_w   = buf_q << w;
            cnt_w   = (cnt_q >= w) ? (cnt_q - w) : '0;
            state_d = S_OUT;
          end else if ((state_q == S_OUT) && block_ready) begin
            state_d = S_RUN;
          end

          // The new byte lands behind whatever survives this cycle's
          // extraction; room is judged on the occupancy before it.
          if (byte_valid) begin
            if (int'(cnt_q) + 8 <= BUF_W) begin
              buf_w = buf_w | (byte_ext >> cnt_w);
              cnt_w = cnt_w + CNT_W'(8);
            end else begin
              ovf_d = 1'b1;
            end
          end

          if (flush) pend_d = 1'b1;

          buf_d = buf_w;
          cnt_d = cnt_w;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset wins over start and every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      // NOTE: the bit buffer is reset too; it is a single register, not a
      // RAM, and its zero fill is what pads a flushed partial block.
      buf_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      blk_q   <= blk_d;
    end
  end

  assign block_valid = (state_q == S_OUT);
  assign block_out   = blk_q;
  assign busy        = (state_q == S_MEASURE);
  assign key_err     = (state_q == S_ERR);
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_block_packer.sv
// Directed bench for block_packer: reset values, modulus measurement,
// block packing with flush padding, back-pressure and overflow, abort by
// start, key error, and reset while a block is held.
module tb_block_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] n_key;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        flush;
  logic        block_ready;
  logic        block_valid;
  logic [31:0] block_out;
  logic        busy;
  logic        key_err;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  block_packer #(.BUF_W(40)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_key       (n_key),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .flush       (flush),
    .block_ready (block_ready),
    .block_valid (block_valid),
    .block_out   (block_out),
    .busy        (busy),
    .key_err     (key_err),
    .ovf         (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic f);
    byte_in    = b;
    byte_valid = 1'b1;
    flush      = f;
    step();
    byte_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] k);
    n_key = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_measure(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'((n <= 15) && !busy), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!block_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(block_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; n_key = '0; byte_in = '0;
    byte_valid = 1'b0; flush = 1'b0; block_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(block_valid), 32'd0);
    check("rst_out",   block_out,        32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_kerr",  32'(key_err),     32'd0);
    check("rst_ovf",   32'(ovf),         32'd0);
    rst = 1'b0;
    step();

    // Byte in IDLE is dropped.
    send(8'h12, 1'b0);
    check("idle_ovf",   32'(ovf),         32'd1);
    check("idle_valid", 32'(block_valid), 32'd0);

    // Measure 3233: 12-bit modulus, W = 11.
    do_start(32'h0000_0CA1);
    check("start_busy",    32'(busy), 32'd1);
    check("start_ovf_clr", 32'(ovf),  32'd0);
    wait_measure("meas_3233");
    check("meas_kerr", 32'(key_err), 32'd0);

    // 0xAB, 0xCD -> 10101011110 = 0x55E, two cycles after the second byte.
    block_ready = 1'b1;
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    check("lat_wait", 32'(block_valid), 32'd0);
    step();
    check("lat_valid", 32'(block_valid), 32'd1);
    check("blk0",      block_out,        32'h55E);
    step();
    check("blk0_ack", 32'(block_valid), 32'd0);

    // Flush the 5 leftover bits 01101 -> 01101000000 = 0x340.
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("flush_valid", 32'(block_valid), 32'd1);
    check("flush_blk",   block_out,        32'h340);
    step();
    check("flush_ack", 32'(block_valid), 32'd0);
    repeat (3) step();
    check("flush_no_more", 32'(block_valid), 32'd0);

    // Flush on an empty buffer emits nothing.
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    check("empty_flush", 32'(block_valid), 32'd0);

    // Back-pressure: hold 0x55E for 10 cycles while bytes fill the buffer.
    block_ready = 1'b0;
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    wait_valid("hold_valid0");
    check("hold_blk0", block_out, 32'h55E);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("fill_no_ovf", 32'(ovf), 32'd0);
    send(8'h55, 1'b0);
    check("fill_ovf", 32'(ovf), 32'd1);
    repeat (5) step();
    check("hold_valid", 32'(block_valid), 32'd1);
    check("hold_blk",   block_out,        32'h55E);
    block_ready = 1'b1;
    step();
    check("hold_ack", 32'(block_valid), 32'd0);
    step();
    // 01101 then 0x11 -> 01101 000100 = 0x344.
    check("next_valid", 32'(block_valid), 32'd1);
    check("next_blk",   block_out,        32'h344);
    block_ready = 1'b0;
    step();

    // start while a block is held aborts it and drops the coincident byte.
    byte_in = 8'h77; byte_valid = 1'b1;
    n_key = 32'h0000_0CA1; start = 1'b1;
    step();
    byte_valid = 1'b0; start = 1'b0;
    check("abort_valid", 32'(block_valid), 32'd0);
    check("abort_busy",  32'(busy),        32'd1);
    check("abort_ovf",   32'(ovf),         32'd0);
    check("abort_out",   block_out,        32'd0);
    wait_measure("meas_again");

    // Byte and flush together on an empty buffer: 0x96 << 3 = 0x4B0.
    block_ready = 1'b1;
    send(8'h96, 1'b1);
    wait_valid("coinc_valid");
    check("coinc_blk", block_out, 32'h4B0);
    repeat (4) step();
    check("coinc_no_more", 32'(block_valid), 32'd0);

    // Modulus 1 is unusable.
    do_start(32'd1);
    wait_measure("meas_one");
    check("kerr_set",   32'(key_err),     32'd1);
    check("kerr_valid", 32'(block_valid), 32'd0);
    send(8'h5A, 1'b1);
    check("err_ovf", 32'(ovf), 32'd1);
    repeat (3) step();
    check("err_stay",  32'(key_err),     32'd1);
    check("err_valid", 32'(block_valid), 32'd0);
    do_start(32'h0000_0CA1);
    check("kerr_clr",     32'(key_err), 32'd0);
    check("kerr_ovf_clr", 32'(ovf),     32'd0);
    wait_measure("meas_after_err");

    // Reset while a block is held, with a coincident start that must lose.
    block_ready = 1'b0;
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    wait_valid("pre_rst_valid");
    check("pre_rst_blk", block_out, 32'h7FF);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("orst_valid", 32'(block_valid), 32'd0);
    check("orst_out",   block_out,        32'd0);
    check("orst_busy",  32'(busy),        32'd0);
    check("orst_kerr",  32'(key_err),     32'd0);
    check("orst_ovf",   32'(ovf),         32'd0);
    step();
    check("orst_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
